wbs_adc_stream_sink: RTL and testbench
======================================

// Module: wbs_adc_stream_sink
// PURPOSE
//  Receiving end of the Wishbone streaming source (wbs_*) that the FMC516 ADC core drives.
//  Accepts pipelined single-write cycles of ADC sample words and buffers them in a FIFO.
//  Frames the words into packets of g_packet_size and hands them to downstream logic
//  (acquisition/DMA) over a valid/ready stream. Reports packet and error statistics.
// PARAMETERS
//  g_wbs_adr_width  4    width of wbs_adr_i (channel/tag field, stored with the data)
//  g_wbs_dat_width  64   width of wbs_dat_i (4 ch x 16 bit samples)
//  g_packet_size    32   words per packet; >=2
//  g_fifo_depth     16   FIFO entries; power of 2, >=4
// PORTS
//  clk_sys_i        in   1            system clock; all logic on rising edge
//  sys_rst_n_i      in   1            synchronous reset, active low
//  wbs_adr_i        in   g_wbs_adr_width  stream address/tag
//  wbs_dat_i        in   g_wbs_dat_width  stream data
//  wbs_cyc_i        in   1            cycle in progress; frames a packet
//  wbs_stb_i        in   1            strobe
//  wbs_we_i         in   1            must be 1; write-only stream
//  wbs_sel_i        in   g_wbs_dat_width/8  byte select; stored, not interpreted
//  wbs_ack_o        out  1            one-cycle ack per accepted write
//  wbs_stall_o      out  1            back-pressure
//  wbs_err_o        out  1            one-cycle error per rejected (read) strobe
//  wbs_rty_o        out  1            constant 0
//  snk_dat_o        out  g_wbs_dat_width  FIFO head data
//  snk_adr_o        out  g_wbs_adr_width  FIFO head tag
//  snk_last_o       out  1            head word is last of packet
//  snk_valid_o      out  1            head valid
//  snk_ready_i      in   1            downstream takes head when valid&ready
//  pkt_cnt_o        out  32           completed packets written into FIFO, wraps
//  err_trunc_o      out  1            sticky: cyc dropped mid-packet
//  err_read_o       out  1            sticky: read strobe seen
//  clr_status_i     in   1            pulse: clears pkt_cnt_o and sticky flags
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, word counter 0, FSM IDLE; reset mid-packet discards FIFO.
//  Accept = cyc & stb & we & !stall_o. Accepted word written to FIFO same edge;
//   wbs_ack_o high the following cycle only (1-cycle latency, one ack per accept).
//  Read strobe (cyc & stb & !we & !stall_o): not stored; wbs_err_o pulses next cycle,
//   err_read_o set; word counter unchanged.
//  wbs_stall_o = (fifo_count == g_fifo_depth), from registered count; a same-cycle pop
//   does not lift stall until next cycle. stb while stalled: no ack, no write.
//  FSM: IDLE --cyc--> RECV; RECV --!cyc & word_cnt==0--> IDLE;
//   RECV --!cyc & word_cnt!=0--> IDLE with err_trunc_o set, word_cnt<=0, last not forced.
//  word_cnt increments per accept; at g_packet_size-1 the word is stored with last=1,
//   word_cnt wraps to 0, pkt_cnt_o+1 (wraps 2^32-1 -> 0). Back-to-back packets in one cyc OK.
//  Output: show-ahead FIFO; word accepted at edge N is visible at snk_*_o from cycle N+1.
//   Pop on snk_valid_o & snk_ready_i. Simultaneous push and pop at full: push refused (stalled);
//   at empty: no bypass, valid rises next cycle.
//  snk_dat_o/snk_adr_o/snk_last_o stable while valid & !ready.
//  clr_status_i takes priority over same-cycle increment/set (result is 0).
// STRUCTURE
//  Shared header wbs_sink_defines.vh: FSM state encodings (IDLE, RECV), default widths,
//   FIFO entry packing {last, sel, adr, dat}.
//  One sub-module: wbs_sink_fifo (sync show-ahead FIFO, count output, full/empty).
//  Top level: accept logic, ack/err regs, FSM, word/packet counters, status flags.
// TESTING
//  1 packet of 32 writes, ready_i=1 -> 32 acks, 32 words out in order, last on 32nd,
//   pkt_cnt_o=1, no flags.
//  ready_i=0, 20 writes, depth 16 -> stall_o high after 16th accept, exactly 16 acks;
//   release ready -> remaining 4 accepted, 20 words out in order, none lost/duplicated.
//  cyc dropped after 10 words -> err_trunc_o=1, pkt_cnt_o=0; next 32-word packet gives
//   last on its 32nd word, pkt_cnt_o=1.
//  One read strobe mid-packet -> err_o pulse, err_read_o=1, no FIFO entry, framing intact.
//  Reset asserted with 8 words buffered -> next cycle valid_o=0, ack/stall/err=0, counters 0.
//  pkt_cnt_o preloaded near 2^32-1 by forcing, 2 packets -> wraps to 1; clr_status_i
//   coincident with packet end -> pkt_cnt_o=0.

Source files
------------

// File: rtl/wbs_adc_stream_sink_pkg.sv
// ============================================================================
// Module      : wbs_adc_stream_sink_pkg
// Description : Shared types and defaults for the ADC Wishbone stream sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wbs_adc_stream_sink_pkg;

    localparam int c_ADR_W      = 4;
    localparam int c_DAT_W      = 64;
    localparam int c_PKT_SIZE   = 32;
    localparam int c_FIFO_DEPTH = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } sink_state_t;

    // FIFO entry is packed as {last, sel, adr, dat}
    function automatic int entry_width(input int adr_w, input int dat_w);
        return 1 + (dat_w / 8) + adr_w + dat_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wbs_adc_stream_sink_if.sv
// ============================================================================
// Module      : wbs_adc_stream_sink_if
// Description : Wishbone streaming write port plus valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wbs_adc_stream_sink_if
    import wbs_adc_stream_sink_pkg::*;
#(
    parameter int ADR_W = c_ADR_W,
    parameter int DAT_W = c_DAT_W
) ();

    logic [ADR_W-1:0]   wbs_adr_i;
    logic [DAT_W-1:0]   wbs_dat_i;
    logic               wbs_cyc_i;
    logic               wbs_stb_i;
    logic               wbs_we_i;
    logic [DAT_W/8-1:0] wbs_sel_i;
    logic               wbs_ack_o;
    logic               wbs_stall_o;
    logic               wbs_err_o;
    logic               wbs_rty_o;

    logic [DAT_W-1:0]   snk_dat_o;
    logic [ADR_W-1:0]   snk_adr_o;
    logic [DAT_W/8-1:0] snk_sel_o;
    logic               snk_last_o;
    logic               snk_valid_o;
    logic               snk_ready_i;

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i,
        output wbs_ack_o, wbs_stall_o, wbs_err_o, wbs_rty_o,
        output snk_dat_o, snk_adr_o, snk_sel_o, snk_last_o, snk_valid_o,
        input  snk_ready_i
    );

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i,
        input  wbs_ack_o, wbs_stall_o, wbs_err_o, wbs_rty_o,
        input  snk_dat_o, snk_adr_o, snk_sel_o, snk_last_o, snk_valid_o,
        output snk_ready_i
    );

endinterface

`default_nettype wire

// File: rtl/wbs_adc_stream_sink_fifo.sv
// ============================================================================
// Module      : wbs_adc_stream_sink_fifo
// Description : Synchronous show-ahead FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbs_adc_stream_sink_fifo
    import wbs_adc_stream_sink_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = c_FIFO_DEPTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_rd_data,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

`default_nettype wire

// File: rtl/wbs_adc_stream_sink.sv
// ============================================================================
// Module      : wbs_adc_stream_sink
// Description : Wishbone ADC stream sink: buffers writes, frames packets,
//               reports packet count and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbs_adc_stream_sink
    import wbs_adc_stream_sink_pkg::*;
#(
    parameter int G_WBS_ADR_WIDTH = c_ADR_W,
    parameter int G_WBS_DAT_WIDTH = c_DAT_W,
    parameter int G_PACKET_SIZE   = c_PKT_SIZE,
    parameter int G_FIFO_DEPTH    = c_FIFO_DEPTH
) (
    input  wire logic                clk_sys_i,
    input  wire logic                sys_rst_n_i,
    wbs_adc_stream_sink_if.slave     wbs,
    output logic [31:0]              pkt_cnt_o,
    output logic                     err_trunc_o,
    output logic                     err_read_o,
    input  wire logic                clr_status_i
);

    localparam int c_SEL_W   = G_WBS_DAT_WIDTH / 8;
    localparam int c_ENTRY_W = entry_width(G_WBS_ADR_WIDTH, G_WBS_DAT_WIDTH);
    localparam int c_WCNT_W  = (G_PACKET_SIZE > 2) ? $clog2(G_PACKET_SIZE) : 1;
    localparam int c_CNT_W   = $clog2(G_FIFO_DEPTH) + 1;
    localparam int c_ADR_LSB = G_WBS_DAT_WIDTH;
    localparam int c_SEL_LSB = G_WBS_DAT_WIDTH + G_WBS_ADR_WIDTH;
    localparam logic [c_WCNT_W-1:0] c_LAST_IDX = c_WCNT_W'(G_PACKET_SIZE - 1);

    sink_state_t          r_state;
    sink_state_t          w_state_nxt;
    logic [c_WCNT_W-1:0]  r_word_cnt;
    logic [c_WCNT_W-1:0]  w_word_cnt_nxt;
    logic                 r_ack;
    logic                 r_err;
    logic [31:0]          r_pkt_cnt;
    logic                 r_err_trunc;
    logic                 r_err_read;

    logic                 w_stall;
    logic                 w_accept;
    logic                 w_read;
    logic                 w_last;
    logic                 w_trunc;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_valid;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head_entry;

    // Stall comes from the registered occupancy, so a pop cannot free a slot
    // for a push in the same cycle.
    assign w_stall  = (w_fifo_count == c_CNT_W'(G_FIFO_DEPTH));
    assign w_accept = wbs.wbs_cyc_i & wbs.wbs_stb_i &  wbs.wbs_we_i & ~w_stall;
    assign w_read   = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~wbs.wbs_we_i & ~w_stall;
    assign w_last   = (r_word_cnt == c_LAST_IDX);

    assign w_push_entry = {w_last, wbs.wbs_sel_i, wbs.wbs_adr_i, wbs.wbs_dat_i};

    wbs_adc_stream_sink_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (G_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_sys_i),
        .rst_n     (sys_rst_n_i),
        .i_push    (w_accept),
        .i_wr_data (w_push_entry),
        .i_pop     (w_pop),
        .o_rd_data (w_head_entry),
        .o_count   (w_fifo_count),
        .o_empty   (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_trunc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wbs.wbs_cyc_i) begin
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (!wbs.wbs_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                    w_trunc     = (r_word_cnt != '0);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A truncated packet restarts framing; the already-buffered words keep last=0
    always_comb begin
        w_word_cnt_nxt = r_word_cnt;
        if (w_trunc) begin
            w_word_cnt_nxt = '0;
        end else if (w_accept) begin
            w_word_cnt_nxt = w_last ? '0 : (r_word_cnt + c_WCNT_W'(1));
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!sys_rst_n_i) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_ack      <= w_accept;
            r_err      <= w_read;
        end
    end

    // Status clear wins over a coincident increment or flag set
    always_ff @(posedge clk_sys_i) begin
        if (!sys_rst_n_i) begin
            r_pkt_cnt   <= '0;
            r_err_trunc <= 1'b0;
            r_err_read  <= 1'b0;
        end else if (clr_status_i) begin
            r_pkt_cnt   <= '0;
            r_err_trunc <= 1'b0;
            r_err_read  <= 1'b0;
        end else begin
            if (w_accept && w_last) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_trunc) begin
                r_err_trunc <= 1'b1;
            end
            if (w_read) begin
                r_err_read <= 1'b1;
            end
        end
    end

    assign w_valid = ~w_empty;
    assign w_pop   = w_valid & wbs.snk_ready_i;

    assign wbs.wbs_ack_o   = r_ack;
    assign wbs.wbs_stall_o = w_stall;
    assign wbs.wbs_err_o   = r_err;
    assign wbs.wbs_rty_o   = 1'b0;

    assign wbs.snk_valid_o = w_valid;
    assign wbs.snk_dat_o   = w_valid ? w_head_entry[G_WBS_DAT_WIDTH-1:0] : '0;
    assign wbs.snk_adr_o   = w_valid ? w_head_entry[c_ADR_LSB +: G_WBS_ADR_WIDTH] : '0;
    assign wbs.snk_sel_o   = w_valid ? w_head_entry[c_SEL_LSB +: c_SEL_W] : '0;
    assign wbs.snk_last_o  = w_valid & w_head_entry[c_ENTRY_W-1];

    assign pkt_cnt_o   = r_pkt_cnt;
    assign err_trunc_o = r_err_trunc;
    assign err_read_o  = r_err_read;

endmodule

`default_nettype wire

// File: tb/tb_wbs_adc_stream_sink.sv
// ============================================================================
// Module      : tb_wbs_adc_stream_sink
// Description : Directed self-checking bench for wbs_adc_stream_sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wbs_adc_stream_sink;

    localparam int ADR_W = 4;
    localparam int DAT_W = 64;
    localparam int PKT   = 32;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic             last;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [31:0] pkt_cnt;
    logic        err_trunc;
    logic        err_read;

    always #5 clk = ~clk;

    wbs_adc_stream_sink_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

    wbs_adc_stream_sink #(
        .G_WBS_ADR_WIDTH (ADR_W),
        .G_WBS_DAT_WIDTH (DAT_W),
        .G_PACKET_SIZE   (PKT),
        .G_FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_sys_i    (clk),
        .sys_rst_n_i  (rst_n),
        .wbs          (bus),
        .pkt_cnt_o    (pkt_cnt),
        .err_trunc_o  (err_trunc),
        .err_read_o   (err_read),
        .clr_status_i (clr)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    word_t exp_q[$];
    word_t rx_q[$];
    int    ack_cnt, err_cnt, ack_lat_bad, err_lat_bad, wr_timeouts, tb_wcnt;
    bit    mon_en = 1'b0;
    logic  exp_ack_nxt = 1'b0;
    logic  exp_err_nxt = 1'b0;

    // Output collector and ack/err latency model, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.snk_valid_o === 1'b1 && bus.snk_ready_i === 1'b1)
                rx_q.push_back({bus.snk_last_o, bus.snk_adr_o, bus.snk_dat_o});
            if (bus.wbs_ack_o === 1'b1) ack_cnt++;
            if (bus.wbs_err_o === 1'b1) err_cnt++;
            if (bus.wbs_ack_o !== exp_ack_nxt) ack_lat_bad++;
            if (bus.wbs_err_o !== exp_err_nxt) err_lat_bad++;
            exp_ack_nxt = rst_n && bus.wbs_cyc_i && bus.wbs_stb_i && bus.wbs_we_i && !bus.wbs_stall_o;
            exp_err_nxt = rst_n && bus.wbs_cyc_i && bus.wbs_stb_i && !bus.wbs_we_i && !bus.wbs_stall_o;
        end
    end

    function automatic logic [DAT_W-1:0] mk_dat(input int t, input int i);
        return {8'(t), 24'hC0FFEE, 32'(i)};
    endfunction

    function automatic int count_bad();
        int bad = 0;
        int n   = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (rx_q[i] !== exp_q[i]) bad++;
        return bad + ((rx_q.size() > exp_q.size()) ? rx_q.size() - exp_q.size()
                                                   : exp_q.size() - rx_q.size());
    endfunction

    task automatic drive_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_sel_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        drive_idle();
        bus.snk_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        rx_q.delete();
        ack_cnt = 0; err_cnt = 0; ack_lat_bad = 0; err_lat_bad = 0;
        wr_timeouts = 0; tb_wcnt = 0;
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] dat,
                             input logic clr_pulse);
        bit ok = 1'b0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = dat[7:0];
        clr           = clr_pulse;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.wbs_stall_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            exp_q.push_back({(tb_wcnt == PKT - 1), adr, dat});
            tb_wcnt = (tb_wcnt == PKT - 1) ? 0 : tb_wcnt + 1;
            @(posedge clk);
            #1;
        end else begin
            wr_timeouts++;
        end
        bus.wbs_stb_i = 1'b0;
        clr           = 1'b0;
    endtask

    task automatic read_strobe();
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_dat_i = '1;
        @(posedge clk);
        #1;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b1;
    endtask

    task automatic end_cycle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        tb_wcnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 1000; t++) begin
            if (rx_q.size() >= exp_q.size()) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (bus.snk_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.snk_valid_o); else n_pass++;
        n_checks++; if (bus.wbs_ack_o !== 1'b0) $display("FAIL rst_ack: got %b want 0", bus.wbs_ack_o); else n_pass++;
        n_checks++; if (bus.wbs_stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.wbs_stall_o); else n_pass++;
        n_checks++; if (bus.wbs_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.wbs_err_o); else n_pass++;
        n_checks++; if (bus.wbs_rty_o !== 1'b0) $display("FAIL rst_rty: got %b want 0", bus.wbs_rty_o); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); else n_pass++;
        n_checks++; if (err_trunc !== 1'b0 || err_read !== 1'b0) $display("FAIL rst_flags: got %b%b want 00", err_trunc, err_read); else n_pass++;
        n_checks++; if (bus.snk_dat_o !== '0) $display("FAIL rst_snk_dat: got %0h want 0", bus.snk_dat_o); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_packet();
        do_reset();
        bus.snk_ready_i = 1'b1;
        for (int i = 0; i < PKT; i++) bus_write(ADR_W'(i), mk_dat(1, i), 1'b0);
        end_cycle();
        wait_drain();
        n_checks++; if (wr_timeouts !== 0) $display("FAIL pkt1_timeouts: got %0d want 0", wr_timeouts); else n_pass++;
        n_checks++; if (ack_cnt !== PKT) $display("FAIL pkt1_acks: got %0d want %0d", ack_cnt, PKT); else n_pass++;
        n_checks++; if (rx_q.size() !== PKT) $display("FAIL pkt1_words: got %0d want %0d", rx_q.size(), PKT); else n_pass++;
        n_checks++; if (count_bad() !== 0) $display("FAIL pkt1_order: got %0d bad want 0", count_bad()); else n_pass++;
        n_checks++; if (rx_q.size() < PKT || rx_q[PKT-1].last !== 1'b1 || rx_q[0].last !== 1'b0)
                        $display("FAIL pkt1_last: got size %0d want last only on word %0d", rx_q.size(), PKT); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd1) $display("FAIL pkt1_cnt: got %0d want 1", pkt_cnt); else n_pass++;
        n_checks++; if (err_trunc !== 1'b0 || err_read !== 1'b0) $display("FAIL pkt1_flags: got %b%b want 00", err_trunc, err_read); else n_pass++;
        n_checks++; if (ack_lat_bad !== 0) $display("FAIL pkt1_ack_latency: got %0d bad want 0", ack_lat_bad); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < DEPTH; i++) bus_write(ADR_W'(i), mk_dat(2, i), 1'b0);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_dat_i = mk_dat(2, DEPTH);
        @(negedge clk);
        n_checks++; if (bus.wbs_stall_o !== 1'b1) $display("FAIL bp_stall_full: got %b want 1", bus.wbs_stall_o); else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++; if (ack_cnt !== DEPTH) $display("FAIL bp_acks_held: got %0d want %0d", ack_cnt, DEPTH); else n_pass++;
        n_checks++; if (rx_q.size() !== 0 || bus.snk_valid_o !== 1'b1)
                        $display("FAIL bp_hold: got rx %0d valid %b want 0/1", rx_q.size(), bus.snk_valid_o); else n_pass++;
        @(posedge clk);
        #1;
        bus.snk_ready_i = 1'b1;
        for (int i = DEPTH; i < 20; i++) bus_write(ADR_W'(i), mk_dat(2, i), 1'b0);
        end_cycle();
        wait_drain();
        n_checks++; if (wr_timeouts !== 0) $display("FAIL bp_timeouts: got %0d want 0", wr_timeouts); else n_pass++;
        n_checks++; if (ack_cnt !== 20) $display("FAIL bp_acks: got %0d want 20", ack_cnt); else n_pass++;
        n_checks++; if (rx_q.size() !== 20 || count_bad() !== 0)
                        $display("FAIL bp_order: got size %0d bad %0d want 20/0", rx_q.size(), count_bad()); else n_pass++;
        n_checks++; if (ack_lat_bad !== 0) $display("FAIL bp_ack_latency: got %0d bad want 0", ack_lat_bad); else n_pass++;
    endtask

    task automatic test_truncation();
        do_reset();
        bus.snk_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) bus_write(ADR_W'(i), mk_dat(3, i), 1'b0);
        end_cycle();
        @(negedge clk);
        n_checks++; if (err_trunc !== 1'b1) $display("FAIL trunc_flag: got %b want 1", err_trunc); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL trunc_pkt_cnt: got %0d want 0", pkt_cnt); else n_pass++;
        @(posedge clk);
        #1;
        for (int i = 0; i < PKT; i++) bus_write(ADR_W'(i + 3), mk_dat(3, 100 + i), 1'b0);
        end_cycle();
        wait_drain();
        n_checks++; if (rx_q.size() !== 10 + PKT || count_bad() !== 0)
                        $display("FAIL trunc_order: got size %0d bad %0d want %0d/0", rx_q.size(), count_bad(), 10 + PKT); else n_pass++;
        n_checks++; if (rx_q.size() < 10 + PKT || rx_q[9].last !== 1'b0 || rx_q[9 + PKT].last !== 1'b1)
                        $display("FAIL trunc_last: got size %0d want last only at word %0d", rx_q.size(), 10 + PKT); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd1) $display("FAIL trunc_pkt_after: got %0d want 1", pkt_cnt); else n_pass++;
    endtask

    task automatic test_read_strobe();
        do_reset();
        bus.snk_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) bus_write(ADR_W'(i), mk_dat(4, i), 1'b0);
        read_strobe();
        @(negedge clk);
        n_checks++; if (bus.wbs_err_o !== 1'b1 || bus.wbs_ack_o !== 1'b0)
                        $display("FAIL rd_err_pulse: got err %b ack %b want 1/0", bus.wbs_err_o, bus.wbs_ack_o); else n_pass++;
        n_checks++; if (err_read !== 1'b1) $display("FAIL rd_flag: got %b want 1", err_read); else n_pass++;
        @(posedge clk);
        #1;
        for (int i = 5; i < PKT; i++) bus_write(ADR_W'(i), mk_dat(4, i), 1'b0);
        end_cycle();
        wait_drain();
        n_checks++; if (rx_q.size() !== PKT || count_bad() !== 0)
                        $display("FAIL rd_order: got size %0d bad %0d want %0d/0", rx_q.size(), count_bad(), PKT); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd1 || err_trunc !== 1'b0)
                        $display("FAIL rd_framing: got pkt %0d trunc %b want 1/0", pkt_cnt, err_trunc); else n_pass++;
        n_checks++; if (err_cnt !== 1 || err_lat_bad !== 0)
                        $display("FAIL rd_err_count: got %0d pulses %0d bad want 1/0", err_cnt, err_lat_bad); else n_pass++;
        n_checks++; if (ack_cnt !== PKT) $display("FAIL rd_acks: got %0d want %0d", ack_cnt, PKT); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < 8; i++) bus_write(ADR_W'(i), mk_dat(5, i), 1'b0);
        end_cycle();
        @(negedge clk);
        n_checks++; if (bus.snk_valid_o !== 1'b1 || err_trunc !== 1'b1)
                        $display("FAIL rstm_pre: got valid %b trunc %b want 1/1", bus.snk_valid_o, err_trunc); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.snk_valid_o !== 1'b0) $display("FAIL rstm_valid: got %b want 0", bus.snk_valid_o); else n_pass++;
        n_checks++; if (bus.wbs_ack_o !== 1'b0 || bus.wbs_stall_o !== 1'b0 || bus.wbs_err_o !== 1'b0)
                        $display("FAIL rstm_bus: got ack %b stall %b err %b want 000", bus.wbs_ack_o, bus.wbs_stall_o, bus.wbs_err_o); else n_pass++;
        n_checks++; if (pkt_cnt !== 32'd0 || err_trunc !== 1'b0 || err_read !== 1'b0)
                        $display("FAIL rstm_status: got pkt %0d flags %b%b want 0/00", pkt_cnt, err_trunc, err_read); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.snk_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (rx_q.size() !== 0) $display("FAIL rstm_discard: got %0d words want 0", rx_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        bus.snk_ready_i = 1'b1;
        force dut.r_pkt_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.r_pkt_cnt;
        for (int i = 0; i < PKT; i++) bus_write(ADR_W'(i), mk_dat(6, i), 1'b0);
        n_checks++; if (pkt_cnt !== 32'd0) $display("FAIL wrap_first: got %0h want 0", pkt_cnt); else n_pass++;
        for (int i = PKT; i < 2 * PKT; i++) bus_write(ADR_W'(i), mk_dat(6, i), 1'b0);
        n_checks++; if (pkt_cnt !== 32'd1) $display("FAIL wrap_second: got %0h want 1", pkt_cnt); else n_pass++;
        read_strobe();
        for (int i = 2 * PKT; i < 3 * PKT - 1; i++) bus_write(ADR_W'(i), mk_dat(6, i), 1'b0);
        n_checks++; if (err_read !== 1'b1) $display("FAIL clr_pre_flag: got %b want 1", err_read); else n_pass++;
        bus_write(4'hF, mk_dat(6, 3 * PKT - 1), 1'b1);
        n_checks++; if (pkt_cnt !== 32'd0 || err_read !== 1'b0)
                        $display("FAIL clr_priority: got pkt %0d rd %b want 0/0", pkt_cnt, err_read); else n_pass++;
        end_cycle();
        wait_drain();
        n_checks++; if (rx_q.size() !== 3 * PKT || count_bad() !== 0)
                        $display("FAIL b2b_order: got size %0d bad %0d want %0d/0", rx_q.size(), count_bad(), 3 * PKT); else n_pass++;
        n_checks++; if (wr_timeouts !== 0 || ack_lat_bad !== 0)
                        $display("FAIL b2b_acks: got %0d timeouts %0d bad want 0/0", wr_timeouts, ack_lat_bad); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        bus.snk_ready_i = 1'b0;
        drive_idle();
        test_reset();
        test_single_packet();
        test_backpressure();
        test_truncation();
        test_read_strobe();
        test_reset_mid_packet();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
